pipeline_stall_ctrl: RTL and testbench



---
 rtl/pipeline_stall_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl
//  Description : Stall/flush controller for the 5-stage core. Turns hazard
//                requests into per-stage write-enable, flush and bubble
//                controls. Holds the multi-cycle memory wait FSM and a
//                saturating stall-cycle statistics counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MEM_EXTRA       extra cycles a long memory access occupies MEM (1..15)
//    STAT_W          width of the stall statistics counter
//  Ports
//    i_clk           clock, rising edge
//    i_reset         synchronous active-high reset
//    i_load_use      load-use hazard (ID)
//    i_mem_long      long memory access in MEM
//    i_branch_taken  taken branch/jump resolved in EX
//    o_pc_write      PC write enable
//    o_ifid_write    IF/ID write enable
//    o_ifid_flush    clear IF/ID to NOP
//    o_idex_bubble   load NOP into ID/EX
//    o_exmem_write   EX/MEM write enable
//    o_memwb_bubble  load NOP into MEM/WB
//    o_mem_release   completing cycle of a long memory access
//    o_stall_cycles  saturating count of cycles with o_pc_write = 0
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int MEM_EXTRA = 1,
    parameter int STAT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load_use,
    input  logic              i_mem_long,
    input  logic              i_branch_taken,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_ifid_flush,
    output logic              o_idex_bubble,
    output logic              o_exmem_write,
    output logic              o_memwb_bubble,
    output logic              o_mem_release,
    output logic [STAT_W-1:0] o_stall_cycles
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [3:0]        c_CNT_INIT = 4'(MEM_EXTRA - 1);
    localparam logic [STAT_W-1:0] c_STAT_MAX = '1;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_next_cnt;
    logic [STAT_W-1:0] r_stall_cycles;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= RUN;
            r_cnt          <= 4'd0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (!o_pc_write && (r_stall_cycles != c_STAT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Free-running pipeline
        o_pc_write     = 1'b1;
        o_ifid_write   = 1'b1;
        o_ifid_flush   = 1'b0;
        o_idex_bubble  = 1'b0;
        o_exmem_write  = 1'b1;
        o_memwb_bubble = 1'b0;
        o_mem_release  = 1'b0;
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;

        if (i_reset) begin
            // Hold every stage register and inject NOPs while in reset
            o_pc_write     = 1'b0;
            o_ifid_write   = 1'b0;
            o_ifid_flush   = 1'b1;
            o_idex_bubble  = 1'b1;
            o_exmem_write  = 1'b0;
            o_memwb_bubble = 1'b1;
            w_next_state   = RUN;
            w_next_cnt     = 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_mem_long) begin
                        // Freeze everything up to MEM; MEM/WB gets bubbles
                        o_pc_write     = 1'b0;
                        o_ifid_write   = 1'b0;
                        o_exmem_write  = 1'b0;
                        o_memwb_bubble = 1'b1;
                        w_next_state   = MEM_WAIT;
                        w_next_cnt     = c_CNT_INIT;
                    end else if (i_branch_taken) begin
                        o_ifid_flush  = 1'b1;
                        o_idex_bubble = 1'b1;
                    end else if (i_load_use) begin
                        o_pc_write    = 1'b0;
                        o_ifid_write  = 1'b0;
                        o_idex_bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        o_pc_write     = 1'b0;
                        o_ifid_write   = 1'b0;
                        o_exmem_write  = 1'b0;
                        o_memwb_bubble = 1'b1;
                        w_next_cnt     = r_cnt - 4'd1;
                    end else begin
                        // Release: the long access completes this cycle, so
                        // i_mem_long (still asserted by the same instruction)
                        // is not treated as a new request.
                        o_mem_release = 1'b1;
                        w_next_state  = RUN;
                        if (i_branch_taken) begin
                            o_ifid_flush  = 1'b1;
                            o_idex_bubble = 1'b1;
                        end else if (i_load_use) begin
                            o_pc_write    = 1'b0;
                            o_ifid_write  = 1'b0;
                            o_idex_bubble = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_ctrl
//  Description : Directed testbench for pipeline_stall_ctrl. Three instances
//                with different MEM_EXTRA / STAT_W share the stimulus; each
//                scenario checks the instance whose parameters it targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    // Control vector order:
    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_bubble, mem_release}
    localparam logic [6:0] c_RST     = 7'b0011010;
    localparam logic [6:0] c_DEF     = 7'b1100100;
    localparam logic [6:0] c_LU      = 7'b0001100;
    localparam logic [6:0] c_BR      = 7'b1111100;
    localparam logic [6:0] c_FRZ     = 7'b0000010;
    localparam logic [6:0] c_REL     = 7'b1100101;
    localparam logic [6:0] c_REL_BR  = 7'b1111101;
    localparam logic [6:0] c_REL_LU  = 7'b0001101;

    logic clk;
    logic rst;
    logic load_use;
    logic mem_long;
    logic branch_taken;

    logic [6:0]  o3, o1, os;
    logic [15:0] s3, s1;
    logic [3:0]  ss;

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_EXTRA(3), .STAT_W(16)) u_dut3 (
        .i_clk(clk), .i_reset(rst), .i_load_use(load_use),
        .i_mem_long(mem_long), .i_branch_taken(branch_taken),
        .o_pc_write(o3[6]), .o_ifid_write(o3[5]), .o_ifid_flush(o3[4]),
        .o_idex_bubble(o3[3]), .o_exmem_write(o3[2]), .o_memwb_bubble(o3[1]),
        .o_mem_release(o3[0]), .o_stall_cycles(s3)
    );

    pipeline_stall_ctrl #(.MEM_EXTRA(1), .STAT_W(16)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_load_use(load_use),
        .i_mem_long(mem_long), .i_branch_taken(branch_taken),
        .o_pc_write(o1[6]), .o_ifid_write(o1[5]), .o_ifid_flush(o1[4]),
        .o_idex_bubble(o1[3]), .o_exmem_write(o1[2]), .o_memwb_bubble(o1[1]),
        .o_mem_release(o1[0]), .o_stall_cycles(s1)
    );

    pipeline_stall_ctrl #(.MEM_EXTRA(2), .STAT_W(4)) u_dut_sat (
        .i_clk(clk), .i_reset(rst), .i_load_use(load_use),
        .i_mem_long(mem_long), .i_branch_taken(branch_taken),
        .o_pc_write(os[6]), .o_ifid_write(os[5]), .o_ifid_flush(os[4]),
        .o_idex_bubble(os[3]), .o_exmem_write(os[2]), .o_memwb_bubble(os[1]),
        .o_mem_release(os[0]), .o_stall_cycles(ss)
    );

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ml, input logic br, input logic lu);
        mem_long     = ml;
        branch_taken = br;
        load_use     = lu;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (o3 !== c_RST) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want %b", o3, c_RST);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o3 !== c_DEF) begin
                n_fail++;
                $display("FAIL idle_ctrl[%0d]: got %b want %b", i, o3, c_DEF);
            end
            step();
        end
        @(negedge clk);
        n_cmp++;
        if (s3 !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_stats: got %0d want 0", s3);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (o3 !== c_LU) begin
            n_fail++;
            $display("FAIL lu_ctrl: got %b want %b", o3, c_LU);
        end
        step();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (o3 !== c_DEF) begin
            n_fail++;
            $display("FAIL lu_after_ctrl: got %b want %b", o3, c_DEF);
        end
        n_cmp++;
        if (s3 !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_stats: got %0d want 1", s3);
        end
        step();
    endtask

    task automatic test_mem_long();
        logic [6:0] exp_seq [0:4];
        exp_seq[0] = c_FRZ;
        exp_seq[1] = c_FRZ;
        exp_seq[2] = c_FRZ;
        exp_seq[3] = c_REL;
        exp_seq[4] = c_DEF;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            // Held through the release cycle; dropped once the access has left MEM
            drive((i < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (o3 !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL mem3_ctrl[T+%0d]: got %b want %b", i, o3, exp_seq[i]);
            end
            step();
        end
        @(negedge clk);
        n_cmp++;
        if (s3 !== 16'd3) begin
            n_fail++;
            $display("FAIL mem3_stats: got %0d want 3", s3);
        end
    endtask

    task automatic test_hazard_in_freeze();
        do_reset();
        drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (o1 !== c_FRZ) begin
            n_fail++;
            $display("FAIL frz_ignore_ctrl: got %b want %b", o1, c_FRZ);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (o1 !== c_REL_BR) begin
            n_fail++;
            $display("FAIL rel_branch_ctrl: got %b want %b", o1, c_REL_BR);
        end
        step();
        // Second access: load-use alone in the release cycle
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (o1 !== c_FRZ) begin
            n_fail++;
            $display("FAIL frz2_ctrl: got %b want %b", o1, c_FRZ);
        end
        step();
        drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (o1 !== c_REL_LU) begin
            n_fail++;
            $display("FAIL rel_lu_ctrl: got %b want %b", o1, c_REL_LU);
        end
        step();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (o1 !== c_DEF) begin
            n_fail++;
            $display("FAIL post_rel_ctrl: got %b want %b", o1, c_DEF);
        end
        // Two freezes plus one load-use stall in a release cycle
        n_cmp++;
        if (s1 !== 16'd3) begin
            n_fail++;
            $display("FAIL frz_stats: got %0d want 3", s1);
        end
        step();
    endtask

    task automatic test_branch_priority();
        do_reset();
        drive(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (o3 !== c_BR) begin
            n_fail++;
            $display("FAIL br_over_lu_ctrl: got %b want %b", o3, c_BR);
        end
        step();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (s3 !== 16'd0) begin
            n_fail++;
            $display("FAIL br_stats: got %0d want 0", s3);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seq [0:3];
        exp_seq[0] = c_FRZ;
        exp_seq[1] = c_REL;
        exp_seq[2] = c_FRZ;
        exp_seq[3] = c_REL;
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o1 !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL b2b_ctrl[%0d]: got %b want %b", i, o1, exp_seq[i]);
            end
            step();
        end
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (s1 !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_stats: got %0d want 2", s1);
        end
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) begin
                @(negedge clk);
                n_cmp++;
                if (ss !== 4'd15) begin
                    n_fail++;
                    $display("FAIL sat_reach: got %0d want 15", ss);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (ss !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d want 15", ss);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (o3 !== c_FRZ) begin
            n_fail++;
            $display("FAIL midwait_frz: got %b want %b", o3, c_FRZ);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o3 !== c_RST) begin
            n_fail++;
            $display("FAIL midwait_rst_ctrl: got %b want %b", o3, c_RST);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o3 !== c_DEF) begin
                n_fail++;
                $display("FAIL after_rst_ctrl[%0d]: got %b want %b", i, o3, c_DEF);
            end
            n_cmp++;
            if (s3 !== 16'd0) begin
                n_fail++;
                $display("FAIL after_rst_stats[%0d]: got %0d want 0", i, s3);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        step();
        test_reset();
        test_load_use();
        test_mem_long();
        test_hazard_in_freeze();
        test_branch_priority();
        test_back_to_back();
        test_saturation();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
